lsu_subword: RTL

Load/store unit that sits directly upstream of the 64KB word-only data RAM and drives its address, write-enable and write-data pins. It adds RISC-V byte and halfword access on top of the RAM's 32-bit interface:
- loads: byte/halfword lane select plus sign or zero extension;
- partial stores: a two-cycle read-modify-write, because the RAM has only a single word write enable.

The RAM is read combinationally and written on the clock edge.

---
 rtl/lsu_subword.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/lsu_subword.sv
// Load/store unit in front of a word-only RAM: lane select and extension for loads, two-cycle RMW for sb/sh.
// Define LSU_MISALIGN_TRAP_EN to pulse misalign_o on misaligned accesses instead of forcing natural alignment.
module lsu_subword #(
  parameter int ADDR_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic [31:0] rdata_o,
  output logic        rvalid_o,
  output logic        misalign_o,
  output logic [31:0] mem_addr_o,
  input  logic [31:0] mem_rdata_i,
  output logic        mem_we_o,
  output logic [31:0] mem_wdata_o
);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-3:0] addr_q;
  logic [31:0]       data_q;
  logic [31:0]       rdata_q;
  logic              rvalid_q;

  logic        accept;
  logic        load_ok;
  logic        store_ok;
  logic        op_ok;
  logic        is_half;
  logic        is_word;
  logic        misaligned;
  logic        trap;
  logic        perform;
  logic        sw_now;
  logic        rmw_now;
  logic [1:0]  off;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;
  logic [31:0] merged;
  logic        unused_addr;

  // Gating with rst_n keeps the RAM write strobe low for the whole reset window.
  assign accept  = req_i & (state == IDLE) & rst_n;

  always_comb begin
    load_ok  = 1'b0;
    store_ok = 1'b0;
    case (funct3_i)
      3'b000, 3'b001, 3'b010: begin
        load_ok  = 1'b1;
        store_ok = 1'b1;
      end
      3'b100, 3'b101: load_ok = 1'b1;
      default: ;
    endcase
  end

  assign op_ok      = we_i ? store_ok : load_ok;
  assign is_half    = (funct3_i[1:0] == 2'b01);
  assign is_word    = (funct3_i[1:0] == 2'b10);
  assign misaligned = (is_half & addr_i[0]) | (is_word & (addr_i[1:0] != 2'b00));

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = op_ok & misaligned;
  assign off  = addr_i[1:0];
`else
  assign trap = 1'b0;
  assign off  = is_word ? 2'b00 : (is_half ? {addr_i[1], 1'b0} : addr_i[1:0]);
`endif

  assign perform = accept & op_ok & ~trap;
  assign sw_now  = perform & we_i & is_word;
  assign rmw_now = perform & we_i & ~is_word;

  always_comb begin
    byte_sel = mem_rdata_i[{off, 3'b000} +: 8];
    half_sel = off[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (funct3_i)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b010:  load_ext = mem_rdata_i;
      3'b100:  load_ext = {24'h0, byte_sel};
      3'b101:  load_ext = {16'h0, half_sel};
      default: load_ext = 32'h0;
    endcase
  end

  always_comb begin
    merged = mem_rdata_i;
    if (is_half) merged[{off[1], 4'b0000} +: 16] = wdata_i[15:0];
    else         merged[{off, 3'b000} +: 8]      = wdata_i[7:0];
  end

  always_comb begin
    state_nxt   = state;
    ready_o     = 1'b0;
    mem_we_o    = 1'b0;
    mem_wdata_o = 32'h0;
    mem_addr_o  = {{(32-ADDR_W){1'b0}}, addr_i[ADDR_W-1:2], 2'b00};
    case (state)
      IDLE: begin
        ready_o = 1'b1;
        if (sw_now) begin
          mem_we_o    = 1'b1;
          mem_wdata_o = wdata_i;
        end
        if (rmw_now) state_nxt = WRITE;
      end
      WRITE: begin
        mem_addr_o  = {{(32-ADDR_W){1'b0}}, addr_q, 2'b00};
        mem_we_o    = 1'b1;
        mem_wdata_o = data_q;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr_q   <= '0;
      data_q   <= 32'h0;
      rdata_q  <= 32'h0;
      rvalid_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      rvalid_q <= accept & ~we_i & ~trap;
      if (accept & ~we_i & ~trap) rdata_q <= load_ok ? load_ext : 32'h0;
      if (rmw_now) begin
        addr_q <= addr_i[ADDR_W-1:2];
        data_q <= merged;
      end
    end
  end

  assign rdata_o  = rdata_q;
  assign rvalid_o = rvalid_q;

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_q <= 1'b0;
    else        misalign_q <= accept & trap;
  end

  assign misalign_o = misalign_q;
`else
  assign misalign_o = 1'b0;
`endif

  // Upper address bits are outside the RAM window.
  assign unused_addr = &{1'b0, addr_i[31:ADDR_W]};

endmodule
